// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-FF synchroniser, integrating debouncer,
// press/release pulse generation and optional hold-to-repeat pulse train.
module key_conditioner #(
  parameter int                N_KEYS         = 9,
  parameter int                ACTIVE_HIGH    = 1,
  parameter int                DEBOUNCE_TICKS = 200,
  parameter int                REPEAT_DELAY   = 5000,
  parameter int                REPEAT_PERIOD  = 1000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK    = 9'b000111111
) (
  input  logic              CP,
  input  logic              CR,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PULSE,
  output logic [N_KEYS-1:0] KEY_RELEASE
);

  localparam int CNT_W  = $clog2(DEBOUNCE_TICKS);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RC_W-1:0]  RC_DELAY  = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0]  RC_PERIOD = RC_W'(REPEAT_PERIOD);
  localparam logic [RC_W-1:0]  RC_ONE    = RC_W'(1);

  typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

  // Normalise so that a pressed key is always 1 from here on.
  logic [N_KEYS-1:0] key_norm;
  assign key_norm = (ACTIVE_HIGH != 0) ? KEY_IN : ~KEY_IN;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      logic             s1_reg;
      logic             s2_reg;
      logic             lvl_reg;
      logic             pulse_reg;
      logic             release_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [RC_W-1:0]  rc_reg;
      state_t           state_reg;
      logic             flip;
      logic             rise;
      logic             fall;

      // The debounced level changes on the edge where the disagreement has
      // lasted long enough; pulses are registered on that same edge.
      assign flip = (s2_reg != lvl_reg) && (cnt_reg == CNT_LAST);
      assign rise = flip && s2_reg;
      assign fall = flip && !s2_reg;

      always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
          s1_reg      <= 1'b0;
          s2_reg      <= 1'b0;
          lvl_reg     <= 1'b0;
          cnt_reg     <= '0;
          pulse_reg   <= 1'b0;
          release_reg <= 1'b0;
          rc_reg      <= '0;
          state_reg   <= IDLE;
        end else begin
          s1_reg <= key_norm[gi];
          s2_reg <= s1_reg;

          if (s2_reg == lvl_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            lvl_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end

          pulse_reg   <= 1'b0;
          release_reg <= fall;

          // A release overrides any repeat pulse due on the same edge.
          if (fall) begin
            state_reg <= IDLE;
            rc_reg    <= '0;
          end else begin
            case (state_reg)
              IDLE: begin
                if (rise) begin
                  pulse_reg <= 1'b1;
                  rc_reg    <= RC_ONE;
                  state_reg <= REPEAT_MASK[gi] ? DELAY : HOLD;
                end
              end
              HOLD: begin
                state_reg <= HOLD;
              end
              DELAY: begin
                if (rc_reg == RC_DELAY) begin
                  pulse_reg <= 1'b1;
                  rc_reg    <= RC_ONE;
                  state_reg <= REPEAT;
                end else begin
                  rc_reg <= rc_reg + 1'b1;
                end
              end
              REPEAT: begin
                if (rc_reg == RC_PERIOD) begin
                  pulse_reg <= 1'b1;
                  rc_reg    <= RC_ONE;
                end else begin
                  rc_reg <= rc_reg + 1'b1;
                end
              end
              default: begin
                state_reg <= IDLE;
                rc_reg    <= '0;
              end
            endcase
          end
        end
      end

      assign KEY_LEVEL[gi]   = lvl_reg;
      assign KEY_PULSE[gi]   = pulse_reg;
      assign KEY_RELEASE[gi] = release_reg;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table, directed multi-cycle corner cases
// and randomized bursts checked against a window-based reference model.
module tb_key_conditioner;

  localparam int         NK   = 2;
  localparam int         DT   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [1:0] MASK = 2'b01;

  logic       cp = 1'b0;
  logic       cr = 1'b1;
  logic [1:0] key_in = 2'b00;
  logic [1:0] key_level;
  logic [1:0] key_pulse;
  logic [1:0] key_release;

  key_conditioner #(
    .N_KEYS(NK), .ACTIVE_HIGH(1), .DEBOUNCE_TICKS(DT),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .CP(cp), .CR(cr), .KEY_IN(key_in),
    .KEY_LEVEL(key_level), .KEY_PULSE(key_pulse), .KEY_RELEASE(key_release)
  );

  always #5 cp = ~cp;

  int checks = 0;
  int passed = 0;

  // Reference model: level flips once the last DT synchronised samples all
  // disagree with it; repeats follow from the press time by arithmetic.
  bit         hist [NK][0:4095];
  int         edge_n;
  bit         m_lvl [NK];
  int         t_press [NK];
  logic [1:0] m_level, m_pulse, m_release;

  typedef struct {
    logic [1:0] in;
    int         n;
    logic [1:0] lvl;
    logic [1:0] pulse;
    logic [1:0] rel;
  } vec_t;
  vec_t tbl [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    edge_n = 0;
    for (int k = 0; k < NK; k++) begin
      m_lvl[k]   = 1'b0;
      t_press[k] = 0;
    end
    m_level = '0; m_pulse = '0; m_release = '0;
  endtask

  task automatic model_edge();
    edge_n++;
    for (int k = 0; k < NK; k++) begin
      bit newl;
      bit all_diff;
      hist[k][edge_n] = key_in[k];
      newl = m_lvl[k];
      if (edge_n >= DT + 2) begin
        all_diff = 1'b1;
        for (int j = edge_n - DT - 1; j <= edge_n - 2; j++)
          if (hist[k][j] == m_lvl[k]) all_diff = 1'b0;
        if (all_diff) newl = !m_lvl[k];
      end
      m_pulse[k]   = 1'b0;
      m_release[k] = m_lvl[k] && !newl;
      if (!m_lvl[k] && newl) begin
        m_pulse[k] = 1'b1;
        t_press[k] = edge_n;
      end else if (m_lvl[k] && newl && MASK[k] && (edge_n - t_press[k] >= RD) &&
                   ((edge_n - t_press[k] - RD) % RP == 0)) begin
        m_pulse[k] = 1'b1;
      end
      m_lvl[k]   = newl;
      m_level[k] = newl;
    end
  endtask

  task automatic step();
    @(posedge cp);
    model_edge();
    #1;
    check("model", {key_level, key_pulse, key_release}, {m_level, m_pulse, m_release});
  endtask

  task automatic wait_pulse(input int k, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (key_pulse[k]) begin
        t = edge_n;
        break;
      end
    end
    checks++;
    if (t >= 0) passed++;
    else $display("FAIL wait_pulse key%0d: got no pulse in 40 edges, required one", k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    // Clean press/release on key 1, glitch, dip, auto-repeat on key 0.
    tbl[0]  = '{2'b10,  5, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{2'b10,  1, 2'b10, 2'b10, 2'b00};
    tbl[2]  = '{2'b10, 24, 2'b10, 2'b00, 2'b00};
    tbl[3]  = '{2'b00,  5, 2'b10, 2'b00, 2'b00};
    tbl[4]  = '{2'b00,  1, 2'b00, 2'b00, 2'b10};
    tbl[5]  = '{2'b00,  3, 2'b00, 2'b00, 2'b00};
    tbl[6]  = '{2'b01,  3, 2'b00, 2'b00, 2'b00};
    tbl[7]  = '{2'b00,  6, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{2'b01,  2, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{2'b00,  1, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{2'b01,  5, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    tbl[12] = '{2'b01,  9, 2'b01, 2'b00, 2'b00};
    tbl[13] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    tbl[14] = '{2'b01,  2, 2'b01, 2'b00, 2'b00};
    tbl[15] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    tbl[16] = '{2'b01,  2, 2'b01, 2'b00, 2'b00};
    tbl[17] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    tbl[18] = '{2'b01,  2, 2'b01, 2'b00, 2'b00};
    tbl[19] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    tbl[20] = '{2'b00,  2, 2'b01, 2'b00, 2'b00};
    tbl[21] = '{2'b00,  1, 2'b01, 2'b01, 2'b00};
    tbl[22] = '{2'b00,  2, 2'b01, 2'b00, 2'b00};
    tbl[23] = '{2'b00,  1, 2'b00, 2'b00, 2'b01};
    tbl[24] = '{2'b00,  4, 2'b00, 2'b00, 2'b00};

    #2 cr = 1'b0;
    repeat (2) @(posedge cp);
    #1 check("reset", {key_level, key_pulse, key_release}, 6'b0);
    $display("reset: outputs=%b", {key_level, key_pulse, key_release});
    #2 cr = 1'b1;
    model_reset();

    for (int i = 0; i < 25; i++) begin
      key_in = tbl[i].in;
      for (int c = 0; c < tbl[i].n; c++) begin
        step();
        check($sformatf("vec%0d", i), {key_level, key_pulse, key_release},
              {tbl[i].lvl, tbl[i].pulse, tbl[i].rel});
      end
      $display("vec %0d: in=%b cycles=%0d lvl=%b pulse=%b rel=%b", i, tbl[i].in,
               tbl[i].n, key_level, key_pulse, key_release);
    end

    // Release timed so the level falls on the t+13 repeat edge.
    key_in = 2'b01;
    wait_pulse(0, t);
    repeat (7) step();
    key_in = 2'b00;
    repeat (3) step();
    check("collide_t10_pulse", key_pulse[0], 1'b1);
    repeat (3) step();
    check("collide_release", key_release[0], 1'b1);
    check("collide_pulse", key_pulse[0], 1'b0);
    $display("collision: edge t+13 pulse=%b release=%b", key_pulse[0], key_release[0]);
    repeat (4) step();

    // Both keys pressed together; only key 0 repeats.
    key_in = 2'b11;
    wait_pulse(0, t);
    check("simul_press", key_pulse, 2'b11);
    repeat (10) step();
    check("simul_repeat", key_pulse, 2'b01);
    $display("simultaneous: press and t+10 pulses checked at edge %0d", edge_n);
    repeat (2) step();

    // Asynchronous reset while both keys are held and key 0 is repeating.
    #2 cr = 1'b0;
    #1 check("async_reset", {key_level, key_pulse, key_release}, 6'b0);
    @(posedge cp);
    #1 check("reset_hold", {key_level, key_pulse, key_release}, 6'b0);
    #2 cr = 1'b1;
    model_reset();
    repeat (5) step();
    check("rst_no_early", key_pulse, 2'b00);
    step();
    check("rst_press", key_pulse, 2'b11);
    repeat (10) step();
    check("rst_repeat", key_pulse, 2'b01);
    $display("reset mid-hold: re-press at edge 6, repeat at edge 16");
    key_in = 2'b00;
    repeat (8) step();

    // Randomized bursts, mixing short glitches with long holds.
    for (int b = 0; b < 60; b++) begin
      int n;
      key_in = 2'($urandom_range(0, 3));
      n = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(7, 30);
      repeat (n) step();
      $display("burst %0d: in=%b cycles=%0d lvl=%b", b, key_in, n, key_level);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions raw push-button inputs before they reach the clock top level: HU, HD, MU, MD, SU, SD, LEAD, EXPORT and CS.
- Each key goes through a 2-FF synchroniser, an integrating debouncer and a press-pulse generator.
- Keys selected by a mask also get an optional hold-to-repeat pulse train, so that holding an up/down key steps the time-setting logic repeatedly.
- Runs on the 10 kHz divider output and sits directly upstream of the timing, alarm and countdown blocks.

Parameters:
- N_KEYS, 9: number of independent key channels.
- ACTIVE_HIGH, 1: 1 = a pressed key reads 1 on KEY_IN; 0 = a pressed key reads 0 (input inverted before synchronising).
- DEBOUNCE_TICKS, 200: number of CP cycles the synchronised input must stay at its new value before the debounced level flips (20 ms at 10 kHz). Must be ≥ 2.
- REPEAT_DELAY, 5000: CP cycles from the press pulse to the first auto-repeat pulse (500 ms). Must be ≥ 2.
- REPEAT_PERIOD, 1000: CP cycles between later auto-repeat pulses (100 ms). Must be ≥ 2.
- REPEAT_MASK, 9'b000111111: bit i = 1 enables auto-repeat on key i.

Ports:
- CP  input  1  clock, 10 kHz divider output.
- CR  input  1  reset, asynchronous, active-low.
- KEY_IN  input  N_KEYS  raw asynchronous button levels.
- KEY_LEVEL  output  N_KEYS  debounced pressed level (1 = pressed).
- KEY_PULSE  output  N_KEYS  one-CP-cycle pulse on a debounced press and on each auto-repeat.
- KEY_RELEASE  output  N_KEYS  one-CP-cycle pulse on a debounced release.

Behaviour:
- Reset:
  - CR = 0 asynchronously clears all synchroniser flops, counters, FSMs and every output to 0.
  - Outputs stay 0 while CR = 0.
  - A key still held when CR deasserts is treated as a new press: it produces a KEY_PULSE after the normal debounce latency.
- Independence: all channels are identical and independent. Simultaneous activity on any number of keys is processed in parallel, with no priority and no interaction.
- Synchroniser:
  - The input is normalised to pressed = 1, then k → s1 → s2 on CP rising edges.
- Debouncer, per key, with counter cnt (width = clog2 of DEBOUNCE_TICKS) and level lvl:
  - If s2 == lvl: cnt ← 0.
  - If s2 ≠ lvl and cnt < DEBOUNCE_TICKS−1: cnt ← cnt+1.
  - If s2 ≠ lvl and cnt == DEBOUNCE_TICKS−1: lvl ← s2, cnt ← 0.
  - Any bounce back to lvl restarts the count, so glitches shorter than DEBOUNCE_TICKS cycles never change lvl.
  - Latency: lvl updates on the (DEBOUNCE_TICKS+2)th CP edge, counting the first edge that samples the new KEY_IN value as edge 1.
- KEY_LEVEL = lvl, registered.
- KEY_RELEASE is asserted on the same edge on which lvl falls 1→0, and lasts one cycle.
- Pulse FSM, per key, registered, with a repeat counter rc sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - IDLE:
    - On the edge where lvl rises: KEY_PULSE = 1 for that cycle, rc ← 1.
    - If the repeat bit is set, go to DELAY; otherwise go to HOLD.
  - HOLD:
    - No further pulses.
    - When lvl falls, go to IDLE.
  - DELAY:
    - rc counts CP edges.
    - When rc == REPEAT_DELAY: KEY_PULSE = 1, rc ← 1, go to REPEAT.
  - REPEAT:
    - When rc == REPEAT_PERIOD: KEY_PULSE = 1, rc ← 1, stay in REPEAT.
  - Pulse timing: with the press pulse at edge t, repeat pulses fall at t+REPEAT_DELAY, then t+REPEAT_DELAY+k·REPEAT_PERIOD.
  - Release: lvl falling in any state gives IDLE with rc ← 0 on that same edge.
  - No KEY_PULSE on the release edge, even if rc reached its terminal value on that edge; the release wins.
- Guarantees:
  - KEY_PULSE is never high on two consecutive cycles.
  - KEY_PULSE and KEY_RELEASE are never high together on one key.
- Counters saturate/reload as described and never wrap silently.

Test Plan (sim params: DEBOUNCE_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_KEYS=2, REPEAT_MASK=2'b01):
- Clean press: KEY_IN[1] rises, first sampled at edge 1, held 30 cycles → KEY_LEVEL[1] = 1 and KEY_PULSE[1] for one cycle at edge 6; no further pulses (no repeat on key 1).
- Glitch rejection: KEY_IN[0] high for 3 cycles, then low → KEY_LEVEL, KEY_PULSE and KEY_RELEASE all stay 0. Repeat with a 1-cycle low dip during a 4-cycle high → debounce restarts and the press is accepted 4 cycles after the dip.
- Auto-repeat: KEY_IN[0] held 30 cycles, press pulse at edge t → KEY_PULSE[0] at t, t+10, t+13, t+16, t+19, …. After release, KEY_RELEASE[0] one cycle on the lvl falling edge and no further pulses.
- Release/repeat collision: release timed so lvl falls exactly at t+13 → KEY_RELEASE[0] = 1 and KEY_PULSE[0] = 0 on that edge.
- Simultaneous keys: both keys pressed on the same cycle → both press pulses on the same edge; only key 0 repeats.
- Reset mid-hold: CR = 0 during REPEAT → all outputs 0 immediately (asynchronous). CR = 1 with the key still held → new press pulse 6 edges later, then the repeat sequence restarts from DELAY.
